// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS writeback slice: writeback source and load kinds,
// the writeback FSM state, and the hard-wired zero register index.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_LINK = 2'd3
  } wb_src_t;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_cpu_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword, extends it,
// or merges partial words into rt for LWL/LWR (little-endian memory).
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  load_t       load_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    result_o = mem_rdata_i;
    byte_v   = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v   = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    case (load_type_i)
      LB:  result_o = {{24{byte_v[7]}}, byte_v};
      LBU: result_o = {24'h0, byte_v};
      LH:  result_o = {{16{half_v[15]}}, half_v};
      LHU: result_o = {16'h0, half_v};
      LW:  result_o = mem_rdata_i;
      // LWL: memory bytes [b:0] land in the upper end of rt
      LWL: begin
        case (addr_lo_i)
          2'd0:    result_o = {mem_rdata_i[7:0],  rt_old_i[23:0]};
          2'd1:    result_o = {mem_rdata_i[15:0], rt_old_i[15:0]};
          2'd2:    result_o = {mem_rdata_i[23:0], rt_old_i[7:0]};
          default: result_o = mem_rdata_i;
        endcase
      end
      // LWR: memory bytes [3:b] land in the lower end of rt
      LWR: begin
        case (addr_lo_i)
          2'd1:    result_o = {rt_old_i[31:24], mem_rdata_i[31:8]};
          2'd2:    result_o = {rt_old_i[31:16], mem_rdata_i[31:16]};
          2'd3:    result_o = {rt_old_i[31:8],  mem_rdata_i[31:24]};
          default: result_o = mem_rdata_i;
        endcase
      end
      default: result_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_writeback.sv
// Writeback sequencer: accepts retiring instructions, waits for load data with a
// timeout, and produces one registered register-file write per instruction.
module mips_cpu_writeback
  import mips_cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  wb_src_t     wb_src,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] link_addr,
  input  load_t       load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt_old,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        WENREG,
  output logic [4:0]  Rd,
  output logic [31:0] RdDATA,
  output logic        wb_error
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wenreg_q;
  logic [4:0]       rd_q;
  logic [31:0]      rddata_q;
  logic             wb_error_q;

  // Load context captured at accept so upstream can move on to the next instruction.
  logic [4:0]       ld_rd_q;
  load_t            ld_type_q;
  logic [1:0]       ld_lo_q;
  logic [31:0]      ld_rt_q;
  logic [31:0]      load_data_d;

  mips_cpu_load_align u_align (
    .load_type_i (ld_type_q),
    .addr_lo_i   (ld_lo_q),
    .mem_rdata_i (mem_rdata),
    .rt_old_i    (ld_rt_q),
    .result_o    (load_data_d)
  );

  assign issue_ready = (state_q == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wenreg_q   <= 1'b0;
      rd_q       <= REG_ZERO;
      rddata_q   <= '0;
      wb_error_q <= 1'b0;
      ld_rd_q    <= REG_ZERO;
      ld_type_q  <= LW;
      ld_lo_q    <= '0;
      ld_rt_q    <= '0;
    end else begin
      wenreg_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_rvalid) wb_error_q <= 1'b1;
          if (issue_valid) begin
            case (wb_src)
              WB_ALU: begin
                if (issue_rd != REG_ZERO) begin
                  wenreg_q <= 1'b1;
                  rd_q     <= issue_rd;
                  rddata_q <= alu_result;
                end
              end
              WB_LINK: begin
                if (issue_rd != REG_ZERO) begin
                  wenreg_q <= 1'b1;
                  rd_q     <= issue_rd;
                  rddata_q <= link_addr;
                end
              end
              WB_LOAD: begin
                ld_rd_q   <= issue_rd;
                ld_type_q <= load_type;
                ld_lo_q   <= addr_lo;
                ld_rt_q   <= rt_old;
                cnt_q     <= '0;
                state_q   <= ST_WAIT_MEM;
              end
              default: ;
            endcase
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rvalid) begin
            state_q <= ST_IDLE;
            // $zero loads still consume the data beat but never write
            if (ld_rd_q != REG_ZERO) begin
              wenreg_q <= 1'b1;
              rd_q     <= ld_rd_q;
              rddata_q <= load_data_d;
            end
          end else if (cnt_q == CNT_LAST) begin
            wb_error_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign WENREG   = wenreg_q;
  assign Rd       = rd_q;
  assign RdDATA   = rddata_q;
  assign wb_error = wb_error_q;

endmodule
